pulse_delay_line: RTL and testbench

- Parameterized one-shot delay element for the PDP-6 core-memory timing chain (memory-cycle pulses T0→T1→T2…).
- Takes a one-clock trigger pulse and emits a one-clock output pulse a fixed wall-clock time later, expressed in ns and converted to clock cycles.
- A single module covers the 100 ns, 200 ns and 1000 ns delay elements (and any other ns value) through parameters.
- Instances chain directly: out of one stage feeds in of the next.

---
 rtl/pdp6_timing_pkg.sv | 12 +
 rtl/pulse_delay_line.sv | 28 ++
 tb/tb_pulse_delay_line.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pdp6_timing_pkg.sv
// pdp6_timing_pkg: shared clock period, standard delay constants and ns-to-cycle conversion.
package pdp6_timing_pkg;
  localparam int CLK_PERIOD_NS = 20;
  localparam int DLY100_NS = 100;
  localparam int DLY200_NS = 200;
  localparam int DLY1000_NS = 1000;
  function automatic int ns2cyc(input int ns, input int period = CLK_PERIOD_NS);
    int c;
    c = (ns + period - 1) / period;
    return c < 1 ? 1 : c;
  endfunction
endpackage

// File: rtl/pulse_delay_line.sv
// pulse_delay_line: one-shot delay, emits a one-clock pulse DELAY_NS after the last trigger cycle.
module pulse_delay_line #(
  parameter int CLK_PERIOD_NS = pdp6_timing_pkg::CLK_PERIOD_NS,
  parameter int DELAY_NS = pdp6_timing_pkg::DLY100_NS,
  localparam int DELAY_CYC = pdp6_timing_pkg::ns2cyc(DELAY_NS, CLK_PERIOD_NS),
  localparam int CW = $clog2(DELAY_CYC + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in,
  output logic          out,
  output logic          busy,
  output logic [CW-1:0] remaining
);
  localparam logic [CW-1:0] LOAD = CW'(DELAY_CYC);
  logic [CW-1:0] cnt;
  // a trigger always reloads, so an expiry coinciding with a retrigger is swallowed
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      cnt <= in ? LOAD : cnt - CW'(cnt != '0);
      out <= !in && cnt == CW'(1);
    end
  assign busy = cnt != '0;
  assign remaining = cnt;
endmodule

// File: tb/tb_pulse_delay_line.sv
// tb_pulse_delay_line: directed and random stimulus on several delay instances against a trigger-time model.
module tb_pulse_delay_line;
  localparam int N = 8;
  localparam int D [N] = '{5, 10, 50, 10, 50, 5, 1, 2};
  logic clk = 1'b0, reset_n = 1'b1, a = 1'b0, b = 1'b0;
  logic [N-1:0] o, bz;
  logic [2:0] r0;
  logic [3:0] r1;
  logic [5:0] r2;
  logic [3:0] r3;
  logic [5:0] r4;
  logic [2:0] r5;
  logic [0:0] r6;
  logic [1:0] r7;
  logic [31:0] rem [N];
  int last [N];
  int e = 0, t, tests = 0, fails = 0;
  int q[$];
  always #10 clk = ~clk;
  assign rem[0] = 32'(r0);
  assign rem[1] = 32'(r1);
  assign rem[2] = 32'(r2);
  assign rem[3] = 32'(r3);
  assign rem[4] = 32'(r4);
  assign rem[5] = 32'(r5);
  assign rem[6] = 32'(r6);
  assign rem[7] = 32'(r7);
  pulse_delay_line #(.DELAY_NS(100))  u100  (.clk(clk), .reset_n(reset_n), .in(a),    .out(o[0]), .busy(bz[0]), .remaining(r0));
  pulse_delay_line #(.DELAY_NS(200))  u200  (.clk(clk), .reset_n(reset_n), .in(a),    .out(o[1]), .busy(bz[1]), .remaining(r1));
  pulse_delay_line #(.DELAY_NS(1000)) u1000 (.clk(clk), .reset_n(reset_n), .in(a),    .out(o[2]), .busy(bz[2]), .remaining(r2));
  pulse_delay_line #(.DELAY_NS(200))  c200  (.clk(clk), .reset_n(reset_n), .in(b),    .out(o[3]), .busy(bz[3]), .remaining(r3));
  pulse_delay_line #(.DELAY_NS(1000)) c1000 (.clk(clk), .reset_n(reset_n), .in(o[3]), .out(o[4]), .busy(bz[4]), .remaining(r4));
  pulse_delay_line #(.DELAY_NS(100))  c100  (.clk(clk), .reset_n(reset_n), .in(o[4]), .out(o[5]), .busy(bz[5]), .remaining(r5));
  pulse_delay_line #(.DELAY_NS(20))   u20   (.clk(clk), .reset_n(reset_n), .in(a),    .out(o[6]), .busy(bz[6]), .remaining(r6));
  pulse_delay_line #(.DELAY_NS(30))   u30   (.clk(clk), .reset_n(reset_n), .in(a),    .out(o[7]), .busy(bz[7]), .remaining(r7));

  // model: out fires exactly D edges after the last edge that saw the input high
  function automatic logic mo(int i);
    return (e - last[i]) == D[i];
  endfunction
  function automatic int mr(int i);
    return (e - last[i] < D[i]) ? D[i] - (e - last[i]) : 0;
  endfunction
  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d] edge %0d: got %0d want %0d", tag, idx, e, got, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("out", i, 32'(o[i]), 32'(mo(i)));
      chk("busy", i, 32'(bz[i]), 32'(mr(i) != 0));
      chk("remaining", i, rem[i], 32'(mr(i)));
    end
  endtask
  task automatic tick(input logic na, input logic nb);
    logic src [N];
    a = na;
    b = nb;
    for (int i = 0; i < N; i++) src[i] = (i == 3) ? b : (i == 4) ? mo(3) : (i == 5) ? mo(4) : a;
    @(posedge clk);
    if (reset_n) for (int i = 0; i < N; i++) if (src[i]) last[i] = e + 1;
    e++;
    @(negedge clk);
    check_all();
  endtask
  task automatic reset_pulse();
    a = 1'b0;
    b = 1'b0;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      last[i] = -1000000;
      chk("rst_out", i, 32'(o[i]), 32'd0);
      chk("rst_busy", i, 32'(bz[i]), 32'd0);
      chk("rst_rem", i, rem[i], 32'd0);
    end
    @(posedge clk);
    e++;
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask
  task automatic expect_pulses(input string tag, input int idx, input int at);
    tests++;
    assert (q.size() == 1 && q[0] == at) else begin
      fails++;
      $error("FAIL %s[%0d]: got %0d pulses first at %0d want 1 at %0d", tag, idx, q.size(), q.size() ? q[0] : -1, at);
    end
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) last[i] = -1000000;
    reset_pulse();
    repeat (5) tick(1'b0, 1'b0);
    // single trigger feeding the standalone stages and the 200->1000->100 chain
    t = e + 1;
    tick(1'b1, 1'b1);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 1'b0);
      if (o[0] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("single_100", 0, 5);
    t = e + 1;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 1'b0);
      if (o[3] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("chain_200", 3, 10);
    t = e + 1;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 1'b0);
      if (o[4] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("chain_1000", 4, 61);
    t = e + 1;
    tick(1'b0, 1'b1);
    for (int k = 0; k < 75; k++) begin
      tick(1'b0, 1'b0);
      if (o[5] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("chain_100", 5, 67);
    // retrigger on the 200 ns stage
    t = e + 1;
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0);
      if (o[1] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("retrigger_200", 1, 14);
    // level input held three cycles on the 1000 ns stage
    t = e + 1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0);
      if (o[2] === 1'b1) q.push_back(e - t);
    end
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, 1'b0);
      if (o[2] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("level_1000", 2, 52);
    // retrigger exactly when the 100 ns stage would expire
    t = e + 1;
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0);
      if (o[0] === 1'b1) q.push_back(e - t);
    end
    expect_pulses("collision_100", 0, 10);
    // reset mid-count discards the pending 200 ns pulse
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    reset_pulse();
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0);
      if (o[1] === 1'b1) q.push_back(e);
    end
    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL reset_discard[1]: got %0d pulses want 0", q.size());
    end
    q.delete();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) reset_pulse();
      else tick(k < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 70) == 0, $urandom_range(0, 80) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
